// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and the 2-bit saturating counter helper
package core_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Two-bit direction counter encodings
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Move the counter one step towards taken (up=1) or not-taken, sticking at the ends
    function automatic logic [1:0] sat2(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (ctr == ST) ? ST : ctr + 2'b01;
        end else begin
            res = (ctr == SNT) ? SNT : ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_array.sv
// rtl/btb_array.sv - direct-mapped BTB storage, one comb read port and one registered update port
module btb_array #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    // lookup port
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [ADDR_W-1:0] rd_target,
    output logic [1:0]        rd_ctr,
    // update port: a resolved branch, or an invalidate request from a non-branch
    input  logic              upd_branch,
    input  logic              upd_inval,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
);
    import core_pkg::*;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];

    logic upd_hit;

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];

    // The update side does its own tag check so the lookup port stays dedicated to fetch
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Valid bits and direction counters: reset, trained by resolved branches, cleared by stale aliases
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_branch) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= sat2(ctr_q[upd_idx], upd_taken);
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= WT;
            end
        end else if (upd_inval && upd_hit) begin
            valid_q[upd_idx] <= 1'b0;
        end
    end

    // Tag and target payload: no reset needed, valid gates every use
    always_ff @(posedge clk) begin
        if (rst && upd_branch && upd_taken) begin
            if (!upd_hit) begin
                tag_q[upd_idx] <= upd_tag;
            end
            target_q[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch PC register, BTB lookup, mispredict redirect and branch statistics
module branch_predictor #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter int              ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic [XLEN-1:0]  if_pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             redirect,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int              IDX_W   = $clog2(ENTRIES);
    localparam int              TAG_W   = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  redirect_pc;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rd_target;
    logic [1:0]       rd_ctr;
    logic             hit;
    logic             mispredict;
    logic             branch_upd;
    logic             alias_inval;

    btb_array #(
        .ADDR_W  (XLEN),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (pc_q[IDX_W+1:2]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_ctr     (rd_ctr),
        .upd_branch (branch_upd),
        .upd_inval  (alias_inval),
        .upd_idx    (ex_pc[IDX_W+1:2]),
        .upd_tag    (ex_pc[XLEN-1:IDX_W+2]),
        .upd_taken  (ex_taken),
        .upd_target (ex_target)
    );

    assign if_pc = pc_q;

    // Fetch-side prediction: taken only on a tag hit with a taken-leaning counter
    always_comb begin
        hit            = rd_valid && (rd_tag == pc_q[XLEN-1:IDX_W+2]);
        if_pred_taken  = hit && rd_ctr[1];
        if_pred_target = if_pred_taken ? rd_target : pc_q + PC_STEP;
    end

    // EX-side check of the carried prediction against the resolved outcome
    always_comb begin
        mispredict  = 1'b0;
        branch_upd  = ex_valid && ex_is_branch;
        alias_inval = ex_valid && !ex_is_branch && ex_pred_taken;
        if (ex_valid) begin
            if (ex_is_branch) begin
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target));
            end else begin
                // A non-branch predicted taken means the BTB hit on an aliased stale entry
                mispredict = ex_pred_taken;
            end
        end
        redirect    = mispredict;
        redirect_pc = ex_taken ? ex_target : ex_pc + PC_STEP;
    end

    // Next-PC select: redirect beats stall, stall beats the predicted path
    always_comb begin
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (stall) begin
            pc_next = pc_q;
        end else begin
            pc_next = if_pred_target;
        end
    end

    // Fetch PC register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Saturating branch and mispredict statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (branch_upd && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (redirect && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispred_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    branch_predictor #(
        .XLEN     (32),
        .ENTRIES  (16),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect       (redirect),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_clear();
        ex_valid       = 1'b0;
        ex_is_branch   = 1'b0;
        ex_pc          = '0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    task automatic ex_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic ex_nb(input logic [31:0] pc);
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b0;
        ex_pc          = pc;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b1;
        ex_pred_target = '0;
    endtask

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        ex_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", if_pc, 32'h0);
        chk("reset_pred_taken", if_pred_taken, 1'b0);
        chk("reset_pred_target", if_pred_target, 32'h4);
        chk("reset_branch_cnt", branch_cnt, 4'd0);
        chk("reset_mispred_cnt", mispred_cnt, 4'd0);
        chk("reset_redirect", redirect, 1'b0);

        // Free run
        rst = 1'b1;
        tick(); chk("run_pc4", if_pc, 32'h4);
        tick(); chk("run_pc8", if_pc, 32'h8);
        tick(); chk("run_pcC", if_pc, 32'hC);

        // Cold taken branch 0x10 -> 0x40
        ex_br(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #1; chk("cold_redirect", redirect, 1'b1);
        tick(); ex_clear(); #1;
        chk("cold_pc", if_pc, 32'h40);
        chk("cold_bcnt", branch_cnt, 4'd1);
        chk("cold_mcnt", mispred_cnt, 4'd1);
        chk("cold_0x40_nohit", if_pred_taken, 1'b0);
        tick(); tick(); tick();
        chk("seq_pc4C", if_pc, 32'h4C);

        // Backward jump 0x4C -> 0x10, cold
        ex_br(32'h4C, 1'b1, 32'h10, 1'b0, 32'h50);
        #1; chk("back_redirect", redirect, 1'b1);
        tick(); ex_clear(); #1;
        chk("refetch_pc", if_pc, 32'h10);
        chk("refetch_pred_taken", if_pred_taken, 1'b1);
        chk("refetch_pred_target", if_pred_target, 32'h40);
        chk("refetch_ctr", dut.u_btb.ctr_q[4], 2'b10);
        chk("refetch_mcnt", mispred_cnt, 4'd2);
        tick(); chk("zero_bubble_pc", if_pc, 32'h40);

        // Loop: two more correctly predicted taken resolutions, then exit
        ex_br(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
        #1; chk("loop_no_redirect", redirect, 1'b0);
        tick(); chk("loop_ctr_11a", dut.u_btb.ctr_q[4], 2'b11);
        chk("loop_pc44", if_pc, 32'h44);
        tick(); chk("loop_ctr_11b", dut.u_btb.ctr_q[4], 2'b11);
        ex_br(32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
        #1; chk("exit_redirect", redirect, 1'b1);
        tick(); ex_clear(); #1;
        chk("exit_pc", if_pc, 32'h14);
        chk("exit_ctr_10", dut.u_btb.ctr_q[4], 2'b10);
        chk("exit_bcnt", branch_cnt, 4'd5);
        chk("exit_mcnt", mispred_cnt, 4'd3);

        // Redirect overrides stall; non-branch alias with a different tag leaves the entry
        stall = 1'b1;
        ex_nb(32'hC);
        #1; chk("stall_redirect", redirect, 1'b1);
        tick(); stall = 1'b0; ex_clear(); #1;
        chk("stall_redirect_pc", if_pc, 32'h10);
        chk("alias_tag_miss_keeps", dut.u_btb.valid_q[3], 1'b1);
        chk("stall_redirect_mcnt", mispred_cnt, 4'd4);

        // Same-cycle update and lookup of idx 4: lookup sees the old counter
        ex_br(32'h10, 1'b0, 32'h40, 1'b0, 32'h14);
        #1;
        chk("same_no_redirect", redirect, 1'b0);
        chk("same_old_pred", if_pred_taken, 1'b1);
        chk("same_old_target", if_pred_target, 32'h40);
        tick(); ex_clear(); #1;
        chk("same_pc", if_pc, 32'h40);
        chk("same_ctr_01", dut.u_btb.ctr_q[4], 2'b01);
        chk("same_bcnt", branch_cnt, 4'd6);

        // Plain stall holds
        stall = 1'b1;
        tick(); chk("stall_hold", if_pc, 32'h40);
        stall = 1'b0;
        tick(); tick(); tick();
        chk("hit4C_pc", if_pc, 32'h4C);
        chk("hit4C_pred", if_pred_taken, 1'b1);
        chk("hit4C_target", if_pred_target, 32'h10);

        // Stale alias invalidation on matching tag, redirect to 0x50
        ex_nb(32'h4C);
        tick(); ex_clear(); #1;
        chk("inval_pc", if_pc, 32'h50);
        chk("inval_valid", dut.u_btb.valid_q[3], 1'b0);
        chk("alias50_nohit", if_pred_taken, 1'b0);
        chk("alias50_target", if_pred_target, 32'h54);

        // Allocating 0x50 evicts 0x10 (same idx, different tag)
        ex_br(32'h50, 1'b1, 32'h100, 1'b0, 32'h54);
        tick(); ex_clear(); #1;
        chk("alloc50_pc", if_pc, 32'h100);
        ex_nb(32'hC);
        tick(); ex_clear(); #1;
        chk("evict_pc", if_pc, 32'h10);
        chk("evict_nohit", if_pred_taken, 1'b0);
        chk("evict_target", if_pred_target, 32'h14);
        chk("evict_mcnt", mispred_cnt, 4'd7);
        chk("evict_bcnt", branch_cnt, 4'd7);

        // PC wrap
        ex_br(32'h200, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h204);
        tick(); ex_clear(); #1;
        chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pred_target", if_pred_target, 32'h0);
        tick(); chk("wrap_pc_zero", if_pc, 32'h0);

        // Saturation: 10 more mispredicted branches from 8/8
        for (int i = 0; i < 10; i++) begin
            ex_br(32'h300, 1'b0, 32'h0, 1'b1, 32'h0);
            tick();
        end
        ex_clear(); #1;
        chk("sat_mcnt", mispred_cnt, 4'd15);
        chk("sat_bcnt", branch_cnt, 4'd15);

        // Asynchronous reset mid-flight with an update pending
        ex_br(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #2 rst = 1'b0;
        #1;
        chk("midrst_pc", if_pc, 32'h0);
        chk("midrst_bcnt", branch_cnt, 4'd0);
        chk("midrst_mcnt", mispred_cnt, 4'd0);
        chk("midrst_valid", dut.u_btb.valid_q, 16'h0);
        chk("midrst_ctr", dut.u_btb.ctr_q[4], 2'b01);
        tick(); ex_clear(); rst = 1'b1; #1;
        chk("midrst_no_update", dut.u_btb.valid_q, 16'h0);
        chk("midrst_pc_hold", if_pc, 32'h0);
        tick(); chk("midrst_run", if_pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
